// File: rtl/nic_buf_if.sv
// nic_buf_if: processor register port and router ring link of nic_buf.
// Bit 0 of every data word is the MSB.
interface nic_buf_if #(parameter int DATA_W = 64);
  logic [1:0] addr;
  logic [0:DATA_W-1] d_in, d_out, net_di, net_do;
  logic nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;
  modport slave(
    input  addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    output d_out, net_ri, net_so, net_do
  );
  modport master(
    output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
    input  d_out, net_ri, net_so, net_do
  );
endinterface

// File: rtl/nic_buf.sv
// nic_buf: NIC with router->processor IN FIFO and processor->router OUT FIFO.
// Define NIC_STATUS_COUNT_EN to make status reads return occupancy counts instead of flags.
module nic_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  nic_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [0:DATA_W-1] in_mem [DEPTH];
  logic [0:DATA_W-1] out_mem [DEPTH];
  logic [AW-1:0] in_rp, in_wp, out_rp, out_wp;
  logic [CW-1:0] in_cnt, out_cnt;
  logic in_ne, out_ne, out_full, rd, in_push, in_pop, out_push, out_pop;
  logic [0:DATA_W-1] in_head, in_stat, out_stat;
  assign in_ne = in_cnt != '0;
  assign out_ne = out_cnt != '0;
  assign out_full = out_cnt == CW'(DEPTH);
  assign rd = bus.nicEn & ~bus.nicWrEn;
  assign bus.net_ri = in_cnt < CW'(DEPTH);
  assign in_push = reset & bus.net_si & bus.net_ri;
  assign in_pop = rd & (bus.addr == 2'd0) & in_ne;
  // A write to a full OUT is dropped even if the ring drains it on the same edge.
  assign out_push = reset & bus.nicEn & bus.nicWrEn & (bus.addr == 2'd2) & ~out_full;
  assign bus.net_do = out_ne ? out_mem[out_rp] : '0;
  // Only the head may leave; a polarity mismatch stalls the whole OUT queue.
  assign bus.net_so = out_ne & bus.net_ro & (bus.net_do[0] == bus.net_polarity);
  assign out_pop = bus.net_so;
  assign in_head = in_ne ? in_mem[in_rp] : '0;
`ifdef NIC_STATUS_COUNT_EN
  assign in_stat = DATA_W'(in_cnt);
  assign out_stat = DATA_W'(out_cnt);
`else
  assign in_stat = DATA_W'(in_ne);
  assign out_stat = DATA_W'(out_full);
`endif
  always_comb
    bus.d_out = !rd ? '0 :
                bus.addr == 2'd0 ? in_head :
                bus.addr == 2'd1 ? in_stat :
                bus.addr == 2'd3 ? out_stat : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_rp <= '0;
      in_wp <= '0;
      in_cnt <= '0;
      out_rp <= '0;
      out_wp <= '0;
      out_cnt <= '0;
    end else begin
      if (in_push) in_wp <= in_wp + AW'(1);
      if (in_pop) in_rp <= in_rp + AW'(1);
      if (out_push) out_wp <= out_wp + AW'(1);
      if (out_pop) out_rp <= out_rp + AW'(1);
      in_cnt <= in_cnt + CW'(in_push) - CW'(in_pop);
      out_cnt <= out_cnt + CW'(out_push) - CW'(out_pop);
    end
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wp] <= bus.net_di;
    if (out_push) out_mem[out_wp] <= bus.d_in;
  end
endmodule

// File: tb/tb_nic_buf.sv
// tb_nic_buf: table-driven vectors plus directed corner sequences for nic_buf (DEPTH=4).
module tb_nic_buf;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int errors = 0;
  nic_buf_if #(.DATA_W(64)) bus();
  nic_buf #(.DATA_W(64), .DEPTH(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] addr;
    logic en, wr;
    logic [63:0] din;
    logic si;
    logic [63:0] di;
    logic ro, pol;
    logic [63:0] dout;
    logic ri, so;
    logic [63:0] dov;
  } vec_t;
  vec_t v [20];
  localparam logic [63:0] A = 64'h8000_0000_0000_00AA;
  function automatic logic [63:0] stat(int c, bit f);
`ifdef NIC_STATUS_COUNT_EN
    return 64'(c);
`else
    return {63'b0, f};
`endif
  endfunction
  function automatic vec_t mk(logic [1:0] a, logic e, logic w, logic [63:0] d, logic s,
                              logic [63:0] di, logic r, logic p, logic [63:0] dout,
                              logic ri, logic so, logic [63:0] dov);
    vec_t t;
    t.addr = a; t.en = e; t.wr = w; t.din = d; t.si = s; t.di = di; t.ro = r; t.pol = p;
    t.dout = dout; t.ri = ri; t.so = so; t.dov = dov;
    return t;
  endfunction
  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(logic [1:0] a, logic e, logic w, logic [63:0] d, logic s,
                       logic [63:0] di, logic r, logic p);
    bus.addr = a; bus.nicEn = e; bus.nicWrEn = w; bus.d_in = d;
    bus.net_si = s; bus.net_di = di; bus.net_ro = r; bus.net_polarity = p;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(int i);
    drive(v[i].addr, v[i].en, v[i].wr, v[i].din, v[i].si, v[i].di, v[i].ro, v[i].pol);
    #1;
    chk($sformatf("v%0d d_out", i), bus.d_out, v[i].dout);
    chk($sformatf("v%0d net_ri", i), 64'(bus.net_ri), 64'(v[i].ri));
    chk($sformatf("v%0d net_so", i), 64'(bus.net_so), 64'(v[i].so));
    chk($sformatf("v%0d net_do", i), bus.net_do, v[i].dov);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, stat(0, 0), 1, 0, 0);
    v[1] = mk(3, 1, 0, 0, 0, 0, 0, 0, stat(0, 0), 1, 0, 0);
    for (int k = 0; k < 5; k++)
      v[2+k] = mk(0, 0, 0, 0, 1, 64'(8'h11 * (k + 1)), 0, 0, 0, k < 4, 0, 0);
    v[7] = mk(1, 1, 0, 0, 0, 0, 0, 0, stat(4, 1), 0, 0, 0);
    for (int k = 0; k < 4; k++)
      v[8+k] = mk(0, 1, 0, 0, 0, 0, 0, 0, 64'(8'h11 * (k + 1)), k != 0, 0, 0);
    v[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v[13] = mk(1, 1, 0, 0, 0, 0, 0, 0, stat(0, 0), 1, 0, 0);
    v[14] = mk(2, 1, 1, A, 0, 0, 1, 0, 0, 1, 0, 0);
    v[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, A);
    v[16] = mk(3, 1, 0, 0, 0, 0, 1, 0, stat(1, 0), 1, 0, A);
    v[17] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, A);
    v[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    v[19] = mk(3, 1, 0, 0, 0, 0, 1, 1, stat(0, 0), 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    #1;
    for (int i = 0; i < 20; i++) run_vec(i);
    // Full OUT: fifth write collides with a pop and must be dropped
    for (int k = 0; k < 4; k++) begin
      drive(2, 1, 1, 64'(k + 1), 0, 0, 0, 0);
      #1;
      chk("fill so", 64'(bus.net_so), 0);
      tick();
    end
    drive(3, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("out full stat", bus.d_out, stat(4, 1));
    tick();
    drive(2, 1, 1, 64'hFF, 0, 0, 1, 0);
    #1;
    chk("drop so", 64'(bus.net_so), 1);
    chk("drop do", bus.net_do, 1);
    tick();
    drive(3, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("after drop stat", bus.d_out, stat(3, 0));
    chk("after drop head", bus.net_do, 2);
    tick();
    for (int k = 2; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk($sformatf("drain so %0d", k), 64'(bus.net_so), 1);
      chk($sformatf("drain do %0d", k), bus.net_do, 64'(k));
      tick();
    end
    #1;
    chk("drained so", 64'(bus.net_so), 0);
    chk("drained do", bus.net_do, 0);
    // Simultaneous IN push/pop across pointer wrap
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 1, 64'(16'h100 + k), 0, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 1, 64'(16'h102 + i), 0, 0);
      #1;
      chk($sformatf("wrap d_out %0d", i), bus.d_out, 64'(16'h100 + i));
      chk($sformatf("wrap ri %0d", i), 64'(bus.net_ri), 1);
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap stat", bus.d_out, stat(2, 1));
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("wrap tail %0d", k), bus.d_out, 64'(16'h10A + k));
      tick();
    end
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap empty stat", bus.d_out, stat(0, 0));
    tick();
    // Reset while both FIFOs hold data
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 64'(8'h31 + k), 0, 0);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(2, 1, 1, 64'(k + 1), 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0, 1, 0);
    #1;
    chk("pre-reset head", bus.d_out, 64'h31);
    reset = 0;
    #1;
    chk("in reset d_out", bus.d_out, 0);
    chk("in reset so", 64'(bus.net_so), 0);
    chk("in reset ri", 64'(bus.net_ri), 1);
    chk("in reset do", bus.net_do, 0);
    tick();
    reset = 1;
    drive(3, 1, 0, 0, 0, 0, 1, 0);
    #1;
    chk("post reset out stat", bus.d_out, stat(0, 0));
    chk("post reset so", 64'(bus.net_so), 0);
    chk("post reset do", bus.net_do, 0);
    tick();
    for (int i = 0; i < 14; i++) run_vec(i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
